alu_cmd_queue: RTL
==================

// Module: alu_cmd_queue
// PURPOSE
//   Command buffer directly upstream of the 8-op ALU stage. Accepts
//   {op, a, b} commands over a valid/ready handshake and holds them in an
//   in-order FIFO.
//   Presents the head command, with a sequence tag, to the ALU over a second
//   valid/ready handshake. The tag lets the downstream result stage match
//   each result to its command.
// PARAMETERS
//   DATA_W  4  operand width for a and b
//   DEPTH   4  FIFO entries; power of two, >= 2
//   TAG_W   3  sequence tag width; tag wraps modulo 2**TAG_W
// PORTS
//   clk        in   1                    rising-edge clock
//   rst_n      in   1                    async active-low reset
//   in_valid   in   1                    upstream command valid
//   in_ready   out  1                    queue can accept a command
//   in_op      in   3                    opcode: 000 mul, 001 add, 010 sub, 011 div, 100 mod, 101 shl1, 110 shr1, 111 gt
//   in_a       in   DATA_W               operand a
//   in_b       in   DATA_W               operand b
//   out_valid  out  1                    head command valid toward ALU
//   out_ready  in   1                    ALU accepts the head command
//   out_op     out  3                    head opcode
//   out_a      out  DATA_W               head operand a
//   out_b      out  DATA_W               head operand b
//   out_tag    out  TAG_W                head sequence tag
//   count      out  $clog2(DEPTH)+1      current occupancy
//   err_div0   out  1                    divide-by-zero drop pulse; tied 0 without macro
//   err_tag    out  TAG_W                tag of the dropped command
// BEHAVIOUR
//   Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
//   Reset values:
//     - FIFO is emptied; in_ready=1, out_valid=0, count=0.
//     - Tag counter, err_div0 and err_tag are cleared to 0.
//     - out_op, out_a, out_b and out_tag are 0 while the queue is empty.
//   Push: in_valid & in_ready. The command is stored with tag = tag_cnt, and
//     tag_cnt increments, wrapping 2**TAG_W-1 -> 0.
//   Pop: out_valid & out_ready. The head advances.
//   Data paths:
//     - out_* are driven combinationally from the head entry.
//     - Minimum latency from push to out_valid is 1 cycle; there is no
//       same-cycle bypass.
//   Ready/valid rules:
//     - in_ready = (count != DEPTH).
//     - When full, in_ready stays 0 even if a pop occurs in the same cycle.
//     - out_valid = (count != 0), excluding the macro drop case.
//     - Once out_valid is asserted, out_* hold stable until popped.
//   Simultaneous push and pop (not full, not empty): count is unchanged and
//     both pointers advance.
//   Pointer wrap: read and write pointers wrap at DEPTH. count distinguishes
//     full from empty.
//   Reset mid-transfer: in-flight commands are discarded and the tag restarts
//     at 0.
// CONFIGURATION
//   Macro: ALU_CMD_DIV0_DROP_EN
//   Defined:
//     - A head entry with op in {011, 100} and b == 0 is never presented;
//       out_valid=0 for that entry.
//     - The entry is popped internally in the cycle it reaches the head.
//     - Next cycle: err_div0=1 for exactly 1 cycle, and err_tag holds that
//       entry's tag.
//     - Back-to-back offending entries give one err_div0 pulse each, on
//       consecutive cycles.
//   Undefined: all commands pass through unchanged; err_div0 and err_tag are
//     tied to 0.
// STRUCTURE
//   Shared package alu_pkg:
//     - Opcode constants OP_MUL, OP_ADD, OP_SUB, OP_DIV, OP_MOD, OP_SHL, OP_SHR, OP_GT.
//     - OP_W = 3.
//     - Command width function: CMD_W = 3 + 2*DATA_W + TAG_W.
//   Sub-module: sync_fifo (WIDTH = CMD_W, DEPTH). It holds the storage,
//     pointers and count; the top level holds the tag counter, handshakes and
//     the div0 drop logic.
// TESTING
//   1. Reset, then push {001, 4, 3}; hold out_ready=0.
//      -> out_valid=1 on the next cycle with out_a=4, out_b=3, out_tag=0.
//      -> Values stay stable until out_ready=1 pops the entry.
//   2. Push 4 commands while out_ready=0.
//      -> count=4 and in_ready=0.
//      -> A 5th push is refused.
//      -> Pops return the commands in order with tags 0, 1, 2, 3.
//   3. Push 10 commands while out_ready=1.
//      -> Tags run 0..7, 0, 1 (wrap).
//      -> count never exceeds 1.
//   4. Full queue, in_valid=1 and out_ready=1 together.
//      -> Pop succeeds, the push is refused, and count goes 4 -> 3.
//   5. With ALU_CMD_DIV0_DROP_EN, push {011, 4, 0} then {000, 4, 3}.
//      -> err_div0 pulses once with err_tag=0.
//      -> The ALU sees only the mul command, with tag 1.
//      -> Without the macro, both commands are presented.
//   6. Assert rst_n=0 mid-stream with 3 entries queued.
//      -> count=0 and out_valid=0 immediately.
//      -> The first push after reset gets tag 0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the ALU command queue and its neighbours.
//   - OP_W      : opcode width
//   - alu_op_e  : the eight ALU opcodes (OP_MUL .. OP_GT)
//   - cmd_w()   : width of one packed queue entry {op, a, b, tag}
//   - is_div_op : true for opcodes that divide by operand b
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MUL = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_GT  = 3'b111
    } alu_op_e;

    function automatic int cmd_w(input int data_w, input int tag_w);
        return OP_W + 2 * data_w + tag_w;
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock in-order FIFO with an occupancy counter.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push, wdata : write request and data (ignored while full)
//     pop         : read request (ignored while empty)
//     rdata       : head entry, combinational; all zeros while empty
//     count       : current occupancy, 0 .. DEPTH
//     full, empty : occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// -----------------------------------------------------------------------------
// alu_cmd_queue
//   Command buffer in front of the 8-op ALU. Commands {op, a, b} arrive over a
//   valid/ready handshake, are tagged with a wrapping sequence number, held in
//   order, and the head is offered to the ALU over a second handshake.
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     in_valid/in_ready          : upstream handshake
//     in_op, in_a, in_b          : upstream command
//     out_valid/out_ready        : ALU-side handshake
//     out_op, out_a, out_b       : head command (zeros when not valid)
//     out_tag                    : head sequence tag
//     count                      : current occupancy
//     err_div0, err_tag          : divide-by-zero drop pulse and dropped tag
//   Build option ALU_CMD_DIV0_DROP_EN: a head DIV/MOD command with b == 0 is
//   discarded instead of presented, and reported one cycle later on
//   err_div0/err_tag. Without it err_div0/err_tag are tied to 0.
// -----------------------------------------------------------------------------
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [DATA_W-1:0]      in_a,
    input  logic [DATA_W-1:0]      in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_W-1:0]        out_op,
    output logic [DATA_W-1:0]      out_a,
    output logic [DATA_W-1:0]      out_b,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_div0,
    output logic [TAG_W-1:0]       err_tag
);

    localparam int CMD_W = cmd_w(DATA_W, TAG_W);

    logic [TAG_W-1:0]  tag_cnt;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CMD_W-1:0]  wr_cmd;
    logic [CMD_W-1:0]  head_cmd;
    logic [OP_W-1:0]   head_op;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [TAG_W-1:0]  head_tag;
    logic              head_drop;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign wr_cmd   = {in_op, in_a, in_b, tag_cnt};
    assign {head_op, head_a, head_b, head_tag} = head_cmd;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_cmd),
        .rdata (head_cmd),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef ALU_CMD_DIV0_DROP_EN
    // An offending head is hidden from the ALU and popped in the same cycle,
    // so consecutive offenders produce one error pulse per cycle.
    assign head_drop = !empty && is_div_op(head_op) && (head_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_div0 <= 1'b0;
            err_tag  <= '0;
        end else begin
            err_div0 <= head_drop;
            if (head_drop) begin
                err_tag <= head_tag;
            end
        end
    end
`else
    assign head_drop = 1'b0;
    assign err_div0  = 1'b0;
    assign err_tag   = '0;
`endif

    assign out_valid = !empty && !head_drop;
    assign pop       = (out_valid && out_ready) || head_drop;

    assign out_op  = out_valid ? head_op  : '0;
    assign out_a   = out_valid ? head_a   : '0;
    assign out_b   = out_valid ? head_b   : '0;
    assign out_tag = out_valid ? head_tag : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt <= '0;
        end else if (push) begin
            tag_cnt <= tag_cnt + 1'b1;
        end
    end

endmodule
